am29xx_slice: RTL and testbench
===============================

# am29xx_slice

One 4-bit microengine slice bundling an Am2901-compatible ALU/register slice and an Am2909/Am2911-compatible microprogram sequencer slice. It is cascaded (ALU carry chain, sequencer carry chain) to build the CPU6 8-bit datapath and 11-bit microcode address. The two halves share only clock and reset. The parameter selects the 2909 or 2911 sequencer flavour.

## Interface
- OR_INPUT, 1, 1 = Am2909 (separate seq_r, seq_or honoured); 0 = Am2911 (AR loads from seq_d, seq_r/seq_or ignored)
- clock  in  1  rising-edge clock, sole clock
- reset  in  1  asynchronous, active-low; clears every register
- alu_d  in  4  direct data input D
- alu_a, alu_b  in  4 each  RAM A/B addresses
- alu_src, alu_op, alu_dest  in  3 each  source, function, destination codes
- alu_cin  in  1  carry in, active high
- ram0_in, ram3_in, q0_in, q3_in  in  1 each  shift fill bits
- alu_y  out  4  Y output
- alu_cout, alu_zero, alu_f3, alu_ovr  out  1 each  carry out, F==0, F[3], overflow
- ram0_out, ram3_out, q0_out, q3_out  out  1 each  shift-out bits
- seq_d, seq_r, seq_or  in  4 each  direct, register, OR inputs
- seq_s  in  2  address source select
- seq_zero_n, seq_cin, seq_re_n, seq_fe_n, seq_pup  in  1 each  zero force, increment carry, AR load, stack enable, push/pop
- seq_y  out  4  microaddress
- seq_cout  out  1  incrementer carry

## Operation
- **ALU RAM and Q.** 16×4 RAM and a 4-bit Q register.
  - A and B RAM reads are combinational.
- **Source (R,S) by alu_src:** 0 AQ, 1 AB, 2 ZQ, 3 ZB, 4 ZA, 5 DA, 6 DQ, 7 DZ (Z = 0).
- **Function by alu_op:** 0 R+S+cin, 1 S+~R+cin, 2 R+~S+cin, 3 R|S, 4 R&S, 5 ~R&S, 6 R^S, 7 ~(R^S).
  - For logic ops (3–7), alu_cout=0 and alu_ovr=0.
  - For arithmetic ops, alu_ovr = carry into bit 3 XOR alu_cout.
- **Destination by alu_dest:**
  - 0: Q←F, Y=F.
  - 1: no write, Y=F.
  - 2: RAM[B]←F, Y=A-data.
  - 3: RAM[B]←F, Y=F.
  - 4: RAM[B]←{ram3_in,F[3:1]}, Q←{q3_in,Q[3:1]}, Y=F.
  - 5: as 4 but Q unchanged.
  - 6: RAM[B]←{F[2:0],ram0_in}, Q←{Q[2:0],q0_in}, Y=F.
  - 7: as 6 but Q unchanged.
- **Shift-out bits:** ram0_out=F[0], q0_out=Q[0], ram3_out=F[3], q3_out=Q[3].
- **Flags:** alu_zero=(F==0); alu_f3=F[3].
- **Sequencer mux by seq_s:** 0 μPC, 1 AR, 2 stack top, 3 seq_d.
  - seq_y = seq_zero_n ? (mux | seq_or) : 0.
  - seq_or is treated as 0 when OR_INPUT=0.
- **Incrementer:** μPC ← seq_y + seq_cin (mod 16) every clock; seq_cout = seq_cin & (seq_y==4'hF).
- **Address register:** AR ← seq_r (seq_d when OR_INPUT=0) when seq_re_n=0.
- **Stack:** 4 words, 2-bit pointer sp, both wrap modulo 4.
  - seq_fe_n=0 & seq_pup=1: sp←sp+1, stack[sp+1]←current μPC.
  - seq_fe_n=0 & seq_pup=0: sp←sp−1.
  - Stack top = stack[sp].
  - Overflow overwrites the oldest entry; underflow wraps without error.

## Timing
- alu_y, flags, shift-outs, seq_y and seq_cout are combinational from the inputs and the current register state.
- RAM, Q, μPC, AR, sp and stack update on the rising clock edge.
- An operation reading and writing the same RAM location sees the old value; the new value is visible next cycle.
- Simultaneous push with seq_s=2: seq_y is the pre-push top.
- Simultaneous AR load with seq_s=1: seq_y is the old AR.
- Reset (async, low) clears RAM, Q, μPC, AR, sp and all stack entries to 0.
  - Outputs then follow combinationally, e.g. seq_y=0 when seq_s=0.
  - Deassertion takes effect at the next rising edge.
- Reset mid-operation discards any pending write.

## Structure
- Shared package `am29xx_pkg`:
  - source codes (AQ..DZ), function codes (ADD, SUBR, SUBS, OR, AND, NOTRS, EXOR, EXNOR), destination codes (QREG..RAMU), sequencer select codes (PC, AR, STK, D).
- Two sub-modules instantiated by the top: `am2901_alu` and `am2909_seq` (carrying the OR_INPUT parameter).
- The top only wires ports.

## Test plan
- **ALU add:** reset; D=5, src=DZ, op=ADD, dest=RAMF, B=3, cin=0 → Y=5; next cycle A=3, src=ZA, dest=NOP → Y=5, zero=0.
- **ALU subtract:** RAM[1]=7, src=AB with A=B=1, op=SUBR, cin=1 → Y=0, alu_zero=1, cout=1, ovr=0.
- **ALU overflow and shift:** D=7 plus Q=1 (ADD, src=DQ) → Y=8, ovr=1. Dest RAMQD with ram3_in=1 → RAM[B]=0xC.
- **Sequencer increment:** seq_s=0, cin=1 from reset → seq_y 0,1,2,…,F,0; seq_cout=1 only while seq_y=F.
- **Stack and AR:**
  - Push at μPC=4, advance, then seq_s=2 → seq_y=4.
  - Five pushes followed by a pop wrap modulo 4.
  - seq_re_n=0 with seq_r=9 (OR_INPUT=0: seq_d=9), then seq_s=1 → seq_y=9.
- **OR and zero:** seq_d=8, seq_or=3, seq_s=3 → seq_y=B (OR_INPUT=1) or 8 (OR_INPUT=0); seq_zero_n=0 → seq_y=0. Async reset mid-run → μPC=0 immediately.

Source files
------------

// File: rtl/am29xx_pkg.sv
// Shared codes for the Am2901-style ALU slice and the Am2909/2911-style sequencer slice.
package am29xx_pkg;

    typedef enum logic [2:0] {AQ, AB, ZQ, ZB, ZA, DA, DQ, DZ} alu_src_e;
    typedef enum logic [2:0] {ADD, SUBR, SUBS, OR, AND, NOTRS, EXOR, EXNOR} alu_fn_e;
    typedef enum logic [2:0] {QREG, NOP, RAMA, RAMF, RAMQD, RAMD, RAMQU, RAMU} alu_dest_e;
    typedef enum logic [1:0] {PC, AR, STK, D} seq_src_e;

    localparam int RAM_WORDS   = 16;
    localparam int STACK_WORDS = 4;

    function automatic logic is_arith(input alu_fn_e fn);
        return (fn == ADD) || (fn == SUBR) || (fn == SUBS);
    endfunction

endpackage

// File: rtl/am2901_alu.sv
// 4-bit ALU/register slice: 16x4 dual-read RAM, Q register, source/function/destination decode.
module am2901_alu
    import am29xx_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] alu_d,
    input  logic [3:0] alu_a,
    input  logic [3:0] alu_b,
    input  logic [2:0] alu_src,
    input  logic [2:0] alu_op,
    input  logic [2:0] alu_dest,
    input  logic       alu_cin,
    input  logic       ram0_in,
    input  logic       ram3_in,
    input  logic       q0_in,
    input  logic       q3_in,
    output logic [3:0] alu_y,
    output logic       alu_cout,
    output logic       alu_zero,
    output logic       alu_f3,
    output logic       alu_ovr,
    output logic       ram0_out,
    output logic       ram3_out,
    output logic       q0_out,
    output logic       q3_out
);

    logic [3:0] ram_reg [RAM_WORDS];
    logic [3:0] q_reg;
    logic [3:0] a_data, b_data;
    logic [3:0] r, s, f;
    logic [3:0] op_x, op_y;
    logic [4:0] sum;
    logic [3:0] sum_lo;
    logic [3:0] ram_next, q_next;
    logic       ram_we, q_we;
    alu_fn_e    fn;
    alu_dest_e  dest;

    assign fn     = alu_fn_e'(alu_op);
    assign dest   = alu_dest_e'(alu_dest);
    assign a_data = ram_reg[alu_a];
    assign b_data = ram_reg[alu_b];

    always_comb begin
        r = 4'h0;
        s = 4'h0;
        case (alu_src_e'(alu_src))
            AQ: begin r = a_data; s = q_reg;  end
            AB: begin r = a_data; s = b_data; end
            ZQ: s = q_reg;
            ZB: s = b_data;
            ZA: s = a_data;
            DA: begin r = alu_d;  s = a_data; end
            DQ: begin r = alu_d;  s = q_reg;  end
            DZ: r = alu_d;
        endcase
    end

    // Subtractions are formed as X + ~Y + cin; sum_lo exposes the carry into bit 3.
    always_comb begin
        op_x = r;
        op_y = s;
        case (fn)
            SUBR:    begin op_x = s; op_y = ~r; end
            SUBS:    begin op_x = r; op_y = ~s; end
            default: begin op_x = r; op_y = s;  end
        endcase
        sum    = {1'b0, op_x} + {1'b0, op_y} + {4'b0, alu_cin};
        sum_lo = {1'b0, op_x[2:0]} + {1'b0, op_y[2:0]} + {3'b0, alu_cin};
    end

    always_comb begin
        f = sum[3:0];
        case (fn)
            OR:      f = r | s;
            AND:     f = r & s;
            NOTRS:   f = ~r & s;
            EXOR:    f = r ^ s;
            EXNOR:   f = ~(r ^ s);
            default: f = sum[3:0];
        endcase
    end

    assign alu_cout = is_arith(fn) ? sum[4] : 1'b0;
    assign alu_ovr  = is_arith(fn) ? (sum_lo[3] ^ sum[4]) : 1'b0;
    assign alu_zero = (f == 4'h0);
    assign alu_f3   = f[3];
    assign alu_y    = (dest == RAMA) ? a_data : f;
    assign ram0_out = f[0];
    assign ram3_out = f[3];
    assign q0_out   = q_reg[0];
    assign q3_out   = q_reg[3];

    always_comb begin
        ram_we   = 1'b1;
        ram_next = f;
        q_we     = 1'b0;
        q_next   = q_reg;
        case (dest)
            QREG:  begin ram_we = 1'b0; q_we = 1'b1; q_next = f; end
            NOP:   ram_we = 1'b0;
            RAMQD: begin ram_next = {ram3_in, f[3:1]}; q_we = 1'b1; q_next = {q3_in, q_reg[3:1]}; end
            RAMD:  ram_next = {ram3_in, f[3:1]};
            RAMQU: begin ram_next = {f[2:0], ram0_in}; q_we = 1'b1; q_next = {q_reg[2:0], q0_in}; end
            RAMU:  ram_next = {f[2:0], ram0_in};
            default: ram_next = f;
        endcase
    end

    // Every word clears on reset, so the RAM is built from per-word registers.
    generate
        for (genvar gi = 0; gi < RAM_WORDS; gi++) begin : g_ram
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    ram_reg[gi] <= 4'h0;
                else if (ram_we && (alu_b == 4'(gi)))
                    ram_reg[gi] <= ram_next;
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            q_reg <= 4'h0;
        else if (q_we)
            q_reg <= q_next;
    end

endmodule

// File: rtl/am2909_seq.sv
// 4-bit microprogram sequencer slice: uPC incrementer, address register, 4-deep wrapping stack.
module am2909_seq
    import am29xx_pkg::*;
#(
    parameter bit OR_INPUT = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] seq_d,
    input  logic [3:0] seq_r,
    input  logic [3:0] seq_or,
    input  logic [1:0] seq_s,
    input  logic       seq_zero_n,
    input  logic       seq_cin,
    input  logic       seq_re_n,
    input  logic       seq_fe_n,
    input  logic       seq_pup,
    output logic [3:0] seq_y,
    output logic       seq_cout
);

    logic [3:0] upc_reg, ar_reg;
    logic [1:0] sp_reg, sp_next, push_idx;
    logic [3:0] stack_reg [STACK_WORDS];
    logic [3:0] or_term, ar_src, mux;
    logic       push, pop;

    // The 2911 flavour has no separate R or OR pins.
    assign or_term = OR_INPUT ? seq_or : 4'h0;
    assign ar_src  = OR_INPUT ? seq_r  : seq_d;

    always_comb begin
        mux = upc_reg;
        case (seq_src_e'(seq_s))
            PC:  mux = upc_reg;
            AR:  mux = ar_reg;
            STK: mux = stack_reg[sp_reg];
            D:   mux = seq_d;
        endcase
    end

    assign seq_y    = seq_zero_n ? (mux | or_term) : 4'h0;
    assign seq_cout = seq_cin & (seq_y == 4'hF);

    assign push     = !seq_fe_n && seq_pup;
    assign pop      = !seq_fe_n && !seq_pup;
    assign push_idx = sp_reg + 2'd1;

    always_comb begin
        sp_next = sp_reg;
        if (push)
            sp_next = push_idx;
        else if (pop)
            sp_next = sp_reg - 2'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            upc_reg <= 4'h0;
            ar_reg  <= 4'h0;
            sp_reg  <= 2'd0;
        end else begin
            upc_reg <= seq_y + {3'b0, seq_cin};
            sp_reg  <= sp_next;
            if (!seq_re_n)
                ar_reg <= ar_src;
        end
    end

    generate
        for (genvar gi = 0; gi < STACK_WORDS; gi++) begin : g_stack
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    stack_reg[gi] <= 4'h0;
                else if (push && (push_idx == 2'(gi)))
                    stack_reg[gi] <= upc_reg;
            end
        end
    endgenerate

endmodule

// File: rtl/am29xx_slice.sv
// One microengine slice: ALU/register slice and sequencer slice sharing clock and reset.
module am29xx_slice
    import am29xx_pkg::*;
#(
    parameter bit OR_INPUT = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] alu_d,
    input  logic [3:0] alu_a,
    input  logic [3:0] alu_b,
    input  logic [2:0] alu_src,
    input  logic [2:0] alu_op,
    input  logic [2:0] alu_dest,
    input  logic       alu_cin,
    input  logic       ram0_in,
    input  logic       ram3_in,
    input  logic       q0_in,
    input  logic       q3_in,
    output logic [3:0] alu_y,
    output logic       alu_cout,
    output logic       alu_zero,
    output logic       alu_f3,
    output logic       alu_ovr,
    output logic       ram0_out,
    output logic       ram3_out,
    output logic       q0_out,
    output logic       q3_out,
    input  logic [3:0] seq_d,
    input  logic [3:0] seq_r,
    input  logic [3:0] seq_or,
    input  logic [1:0] seq_s,
    input  logic       seq_zero_n,
    input  logic       seq_cin,
    input  logic       seq_re_n,
    input  logic       seq_fe_n,
    input  logic       seq_pup,
    output logic [3:0] seq_y,
    output logic       seq_cout
);

    am2901_alu u_alu (
        .clock    (clock),
        .reset    (reset),
        .alu_d    (alu_d),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_src  (alu_src),
        .alu_op   (alu_op),
        .alu_dest (alu_dest),
        .alu_cin  (alu_cin),
        .ram0_in  (ram0_in),
        .ram3_in  (ram3_in),
        .q0_in    (q0_in),
        .q3_in    (q3_in),
        .alu_y    (alu_y),
        .alu_cout (alu_cout),
        .alu_zero (alu_zero),
        .alu_f3   (alu_f3),
        .alu_ovr  (alu_ovr),
        .ram0_out (ram0_out),
        .ram3_out (ram3_out),
        .q0_out   (q0_out),
        .q3_out   (q3_out)
    );

    am2909_seq #(.OR_INPUT(OR_INPUT)) u_seq (
        .clock      (clock),
        .reset      (reset),
        .seq_d      (seq_d),
        .seq_r      (seq_r),
        .seq_or     (seq_or),
        .seq_s      (seq_s),
        .seq_zero_n (seq_zero_n),
        .seq_cin    (seq_cin),
        .seq_re_n   (seq_re_n),
        .seq_fe_n   (seq_fe_n),
        .seq_pup    (seq_pup),
        .seq_y      (seq_y),
        .seq_cout   (seq_cout)
    );

endmodule

// File: tb/tb_am29xx_slice.sv
// Directed-vector bench for am29xx_slice (2909 flavour) with hand-computed expectations.
module tb_am29xx_slice;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] alu_d, alu_a, alu_b;
    logic [2:0] alu_src, alu_op, alu_dest;
    logic       alu_cin, ram0_in, ram3_in, q0_in, q3_in;
    logic [3:0] alu_y;
    logic       alu_cout, alu_zero, alu_f3, alu_ovr;
    logic       ram0_out, ram3_out, q0_out, q3_out;
    logic [3:0] seq_d, seq_r, seq_or;
    logic [1:0] seq_s;
    logic       seq_zero_n, seq_cin, seq_re_n, seq_fe_n, seq_pup;
    logic [3:0] seq_y;
    logic       seq_cout;

    int errors = 0;
    int checks = 0;

    am29xx_slice #(.OR_INPUT(1'b1)) dut (
        .clock(clock), .reset(reset),
        .alu_d(alu_d), .alu_a(alu_a), .alu_b(alu_b),
        .alu_src(alu_src), .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
        .ram0_in(ram0_in), .ram3_in(ram3_in), .q0_in(q0_in), .q3_in(q3_in),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_f3(alu_f3), .alu_ovr(alu_ovr),
        .ram0_out(ram0_out), .ram3_out(ram3_out), .q0_out(q0_out), .q3_out(q3_out),
        .seq_d(seq_d), .seq_r(seq_r), .seq_or(seq_or), .seq_s(seq_s),
        .seq_zero_n(seq_zero_n), .seq_cin(seq_cin), .seq_re_n(seq_re_n),
        .seq_fe_n(seq_fe_n), .seq_pup(seq_pup),
        .seq_y(seq_y), .seq_cout(seq_cout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic alu_set(input logic [2:0] src, input logic [2:0] op, input logic [2:0] dest,
                           input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
                           input logic cin);
        alu_src = src; alu_op = op; alu_dest = dest;
        alu_d = d; alu_a = a; alu_b = b; alu_cin = cin;
        #1;
    endtask

    // Load uPC with v through the D path, then push it.
    task automatic push_val(input logic [3:0] v);
        seq_s = 2'd3; seq_d = v; seq_cin = 1'b0;
        tick();
        seq_s = 2'd0; seq_fe_n = 1'b0; seq_pup = 1'b1;
        tick();
        seq_fe_n = 1'b1;
    endtask

    task automatic pop_one();
        seq_s = 2'd0; seq_fe_n = 1'b0; seq_pup = 1'b0;
        tick();
        seq_fe_n = 1'b1;
    endtask

    // Source codes: AQ0 AB1 ZQ2 ZB3 ZA4 DA5 DQ6 DZ7; ops: ADD0 SUBR1 SUBS2 OR3 ...
    // Dests: QREG0 NOP1 RAMA2 RAMF3 RAMQD4 RAMD5 RAMQU6 RAMU7
    initial begin
        reset = 1'b0;
        alu_d = 0; alu_a = 0; alu_b = 0; alu_src = 3'd4; alu_op = 3'd0; alu_dest = 3'd1; alu_cin = 0;
        ram0_in = 0; ram3_in = 0; q0_in = 0; q3_in = 0;
        seq_d = 0; seq_r = 0; seq_or = 0; seq_s = 0;
        seq_zero_n = 1; seq_cin = 0; seq_re_n = 1; seq_fe_n = 1; seq_pup = 0;
        #3;
        check("rst_seq_y", seq_y, 4'h0);
        check("rst_alu_y", alu_y, 4'h0);
        check("rst_zero", 4'(alu_zero), 4'h1);
        alu_set(3'd2, 3'd0, 3'd1, 4'h0, 4'h0, 4'h0, 1'b0);
        check("rst_q", alu_y, 4'h0);
        reset = 1'b1;
        tick();

        // ALU add into RAM[3], then read back
        alu_set(3'd7, 3'd0, 3'd3, 4'h5, 4'h0, 4'h3, 1'b0);
        check("add_y", alu_y, 4'h5);
        tick();
        alu_set(3'd4, 3'd0, 3'd1, 4'h0, 4'h3, 4'h0, 1'b0);
        check("add_read", alu_y, 4'h5);
        check("add_zero", 4'(alu_zero), 4'h0);

        // Subtract RAM[1]-RAM[1]
        alu_set(3'd7, 3'd0, 3'd3, 4'h7, 4'h0, 4'h1, 1'b0);
        tick();
        alu_set(3'd1, 3'd1, 3'd1, 4'h0, 4'h1, 4'h1, 1'b1);
        check("sub_y", alu_y, 4'h0);
        check("sub_zero", 4'(alu_zero), 4'h1);
        check("sub_cout", 4'(alu_cout), 4'h1);
        check("sub_ovr", 4'(alu_ovr), 4'h0);

        // Overflow: Q=1, D=7 -> 8, shifted down into RAM[2] with ram3_in=1
        alu_set(3'd7, 3'd0, 3'd0, 4'h1, 4'h0, 4'h0, 1'b0);
        tick();
        ram3_in = 1'b1;
        alu_set(3'd6, 3'd0, 3'd4, 4'h7, 4'h0, 4'h2, 1'b0);
        check("ovr_y", alu_y, 4'h8);
        check("ovr_ovr", 4'(alu_ovr), 4'h1);
        check("ovr_f3", 4'(alu_f3), 4'h1);
        check("ovr_cout", 4'(alu_cout), 4'h0);
        check("ovr_q0", 4'(q0_out), 4'h1);
        tick();
        ram3_in = 1'b0;
        alu_set(3'd4, 3'd0, 3'd1, 4'h0, 4'h2, 4'h0, 1'b0);
        check("shr_ram", alu_y, 4'hC);
        alu_set(3'd2, 3'd0, 3'd1, 4'h0, 4'h0, 4'h0, 1'b0);
        check("shr_q", alu_y, 4'h0);

        // Logic op: D | RAM[2] = 3 | C
        alu_set(3'd5, 3'd3, 3'd1, 4'h3, 4'h2, 4'h0, 1'b1);
        check("or_y", alu_y, 4'hF);
        check("or_cout", 4'(alu_cout), 4'h0);
        alu_set(3'd5, 3'd7, 3'd1, 4'h3, 4'h2, 4'h0, 1'b0);
        check("exnor_y", alu_y, 4'h0);

        // Shift up into RAM[6] and Q, then RAMA shows A-data
        ram0_in = 1'b1; q0_in = 1'b1;
        alu_set(3'd7, 3'd0, 3'd6, 4'h5, 4'h0, 4'h6, 1'b0);
        check("shl_y", alu_y, 4'h5);
        check("shl_r0out", 4'(ram0_out), 4'h1);
        check("shl_r3out", 4'(ram3_out), 4'h0);
        tick();
        ram0_in = 1'b0; q0_in = 1'b0;
        check("shl_q0", 4'(q0_out), 4'h1);
        alu_set(3'd7, 3'd0, 3'd2, 4'h2, 4'h6, 4'h7, 1'b0);
        check("rama_y", alu_y, 4'hB);
        tick();
        alu_set(3'd4, 3'd0, 3'd1, 4'h0, 4'h7, 4'h0, 1'b0);
        check("rama_wr", alu_y, 4'h2);

        // Read and write same location: old value seen, new value next cycle
        alu_set(3'd4, 3'd0, 3'd3, 4'h0, 4'h5, 4'h5, 1'b1);
        check("rmw_1", alu_y, 4'h1);
        tick();
        check("rmw_2", alu_y, 4'h2);
        alu_set(3'd4, 3'd0, 3'd1, 4'h0, 4'h0, 4'h0, 1'b0);

        // Sequencer increment from uPC=0
        seq_cin = 1'b1;
        for (int i = 0; i < 17; i++) begin
            check($sformatf("inc_y%0d", i), seq_y, 4'(i));
            check($sformatf("inc_co%0d", i), 4'(seq_cout), (i == 15) ? 4'h1 : 4'h0);
            tick();
        end
        tick();

        // Async reset mid-run
        reset = 1'b0;
        #1;
        check("async_seq_y", seq_y, 4'h0);
        alu_set(3'd4, 3'd0, 3'd1, 4'h0, 4'h2, 4'h0, 1'b0);
        check("async_ram", alu_y, 4'h0);
        seq_cin = 1'b0;
        reset = 1'b1;
        tick();

        // Push at uPC=4, advance, read stack top
        push_val(4'h4);
        seq_cin = 1'b1;
        tick();
        seq_cin = 1'b0;
        #1;
        check("adv_upc", seq_y, 4'h5);
        seq_s = 2'd2;
        #1;
        check("stk_top", seq_y, 4'h4);
        seq_s = 2'd0;

        // Five pushes from sp=1 wrap and overwrite the oldest
        for (int i = 1; i <= 5; i++) push_val(4'(i));
        seq_s = 2'd2; #1;
        check("wrap_top", seq_y, 4'h5);
        pop_one(); seq_s = 2'd2; #1;
        check("pop1", seq_y, 4'h4);
        pop_one(); seq_s = 2'd2; #1;
        check("pop2", seq_y, 4'h3);
        pop_one(); seq_s = 2'd2; #1;
        check("pop3", seq_y, 4'h2);
        pop_one(); seq_s = 2'd2; #1;
        check("pop4_wrap", seq_y, 4'h5);
        seq_fe_n = 1'b0; seq_pup = 1'b1; #1;
        check("push_pre_top", seq_y, 4'h5);
        seq_fe_n = 1'b1; seq_s = 2'd0;

        // Address register load
        seq_r = 4'h9; seq_d = 4'h6; seq_re_n = 1'b0; seq_s = 2'd1; #1;
        check("ar_old", seq_y, 4'h0);
        tick();
        seq_re_n = 1'b1; #1;
        check("ar_new", seq_y, 4'h9);

        // OR input and zero force
        seq_d = 4'h8; seq_or = 4'h3; seq_s = 2'd3; #1;
        check("or_seq_y", seq_y, 4'hB);
        seq_zero_n = 1'b0; #1;
        check("zero_seq_y", seq_y, 4'h0);
        seq_zero_n = 1'b1; seq_or = 4'h0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
